// File: rtl/sdpb_ram.sv
// sdpb_ram: simple dual-port RAM, one write port (A) and one read port (B), optional output pipeline register
module sdpb_ram #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH = 65536,
  parameter int READ_MODE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cea,
  input  logic                  reseta,
  input  logic [ADDR_WIDTH-1:0] ada,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ceb,
  input  logic                  resetb,
  input  logic                  oce,
  input  logic [ADDR_WIDTH-1:0] adb,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd_d, rd_q, out_d, out_q;
  logic we, rd_ok;
  always_comb begin
    we = reset && cea && !reseta && (32'(ada) < DEPTH);
    rd_ok = 32'(adb) < DEPTH;
    rd_d = resetb ? '0 : ceb ? (rd_ok ? mem[adb] : '0) : rd_q;
    out_d = resetb ? '0 : oce ? rd_q : out_q;
  end
  // Memory array has no reset so it maps onto block RAM; the read above sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[ada] <= din;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
      out_q <= '0;
    end else begin
      rd_q <= rd_d;
      out_q <= out_d;
    end
  end
  assign dout = (READ_MODE != 0) ? out_q : rd_q;
endmodule

// File: tb/tb_sdpb_ram.sv
// tb_sdpb_ram: directed scoreboard bench for sdpb_ram in pipelined and bypass read modes
module tb_sdpb_ram;
  logic clk = 0, reset = 0;
  logic cea = 0, reseta = 0, ceb = 0, resetb = 0, oce = 0;
  logic [15:0] ada = '0, adb = '0;
  logic [1:0] din = '0, dout;
  logic cea0 = 0, ceb0 = 0, oce0 = 0, rsta0 = 0, rstb0 = 0;
  logic [15:0] ada0 = '0, adb0 = '0;
  logic [1:0] din0 = '0, dout0;
  logic [1:0] exp_q[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sdpb_ram #(.READ_MODE(1)) dut (
    .clk(clk), .reset(reset), .cea(cea), .reseta(reseta), .ada(ada), .din(din),
    .ceb(ceb), .resetb(resetb), .oce(oce), .adb(adb), .dout(dout)
  );

  sdpb_ram #(.READ_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .cea(cea0), .reseta(rsta0), .ada(ada0), .din(din0),
    .ceb(ceb0), .resetb(rstb0), .oce(oce0), .adb(adb0), .dout(dout0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed %b expected <scoreboard empty>", tag, dout);
    end else begin
      e = exp_q.pop_front();
      check(tag, dout, e);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [1:0] d);
    cea = 1; ada = a; din = d;
    step();
    cea = 0;
  endtask

  initial begin
    step();
    step();
    check("reset_dout", dout, 2'b00);
    check("reset_dout0", dout0, 2'b00);
    reset = 1;
    // 1: basic write then 2-edge pipelined read
    wr(16'h0005, 2'b10);
    ceb = 1; adb = 16'h0005; exp_q.push_back(2'b10);
    step();
    ceb = 0; oce = 1;
    check("t1_before_oce", dout, 2'b00);
    step();
    oce = 0;
    check_sb("t1_read");
    // 2: read-first on same-edge read/write collision
    wr(16'h0100, 2'b01);
    cea = 1; ada = 16'h0100; din = 2'b11;
    ceb = 1; adb = 16'h0100; oce = 1;
    exp_q.push_back(2'b01);
    step();
    cea = 0; exp_q.push_back(2'b11);
    step();
    ceb = 0;
    check_sb("t2_old_data");
    step();
    check_sb("t2_new_data");
    // 3: writes blocked by reseta and by cea=0
    wr(16'h1234, 2'b00);
    reseta = 1; cea = 1; ada = 16'h1234; din = 2'b11;
    step();
    reseta = 0; cea = 0;
    step();
    ceb = 1; adb = 16'h1234; exp_q.push_back(2'b00);
    step();
    ceb = 0;
    step();
    check_sb("t3_blocked");
    // 4: fill then bubble-free streaming read
    for (int i = 0; i < 12; i++) wr(16'(i), 2'(3 - i % 4));
    oce = 1;
    for (int i = 0; i <= 12; i++) begin
      ceb = (i < 12);
      if (i < 12) begin
        adb = 16'(i);
        exp_q.push_back(2'(3 - i % 4));
      end
      step();
      if (i >= 1) check_sb($sformatf("t4_stream_%0d", i - 1));
    end
    ceb = 0;
    // 5: resetb clear (winning over ceb), async reset, data retention
    wr(16'h0200, 2'b10);
    ceb = 1; adb = 16'h0200;
    step();
    ceb = 0;
    step();
    check("t5_hold", dout, 2'b10);
    resetb = 1; ceb = 1;
    step();
    resetb = 0; ceb = 0;
    check("t5_resetb", dout, 2'b00);
    step();
    check("t5_resetb_wins", dout, 2'b00);
    ceb = 1;
    step();
    ceb = 0;
    step();
    check("t5_reread", dout, 2'b10);
    #2 reset = 0;
    #1;
    check("t5_async_reset", dout, 2'b00);
    cea = 1; ada = 16'h0200; din = 2'b01;
    step();
    cea = 0;
    reset = 1;
    ceb = 1; adb = 16'h0200; exp_q.push_back(2'b10);
    step();
    ceb = 0;
    step();
    check_sb("t5_retained");
    oce = 0;
    // 6: bypass instance, 1-edge latency and hold with ceb=0
    cea0 = 1; ada0 = 16'hFFFF; din0 = 2'b01;
    step();
    cea0 = 0;
    ceb0 = 1; adb0 = 16'hFFFF;
    step();
    ceb0 = 0; adb0 = 16'h0005;
    check("t6_bypass", dout0, 2'b01);
    step();
    adb0 = 16'h0010;
    check("t6_hold_a", dout0, 2'b01);
    step();
    check("t6_hold_b", dout0, 2'b01);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL sb_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
